// File: rtl/ark_acc_pkg.sv
// Shared types and defaults for the accumulator store-drain path.
package ark_acc_pkg;

  typedef enum logic {
    DRN_IDLE = 1'b0,
    DRN_REQ  = 1'b1
  } drain_state_t;

  localparam int DRAIN_DEPTH = 4;

endpackage

// File: rtl/acc_fifo.sv
// Snapshot FIFO: power-of-two ring buffer with a separate level counter so
// full and empty are distinguished exactly.
module acc_fifo
  import ark_acc_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = DRAIN_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: storage is not reset; the control state guarantees no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/acc_store_drain.sv
// Snapshots accumulator values into a FIFO and drains them to data memory
// through a req/ack write port with an auto-incrementing address.
module acc_store_drain
  import ark_acc_pkg::*;
#(
  parameter int W     = 8,
  parameter int A     = 8,
  parameter int DEPTH = DRAIN_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Capture,
  input  logic [W-1:0]           AccData,
  input  logic                   LoadBase,
  input  logic [A-1:0]           BaseAddr,
  output logic                   MemWrEn,
  output logic [A-1:0]           MemAddr,
  output logic [W-1:0]           MemData,
  input  logic                   MemAck,
  output logic                   Full,
  output logic                   Empty,
  output logic [$clog2(DEPTH):0] Level,
  output logic                   Overflow,
  output logic                   Busy
);

  localparam int LW = $clog2(DEPTH) + 1;

  drain_state_t  state_q, state_d;
  logic [A-1:0]  addr_q, addr_d;
  logic          overflow_q, overflow_d;
  logic          pop;
  logic          load_ok;
  logic [W-1:0]  head;

  acc_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .push    (Capture),
    .pop     (pop),
    .wr_data (AccData),
    .rd_data (head),
    .level   (Level),
    .full    (Full),
    .empty   (Empty)
  );

  assign Busy    = (state_q != DRN_IDLE) || !Empty;
  assign load_ok = LoadBase && !Busy;

  assign MemWrEn = (state_q == DRN_REQ);
  assign MemAddr = addr_q;
  // Head is masked outside REQ so MemData reads zero from reset without resetting storage.
  assign MemData = (state_q == DRN_REQ) ? head : '0;

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    overflow_d = overflow_q;
    pop        = 1'b0;

    case (state_q)
      DRN_IDLE: begin
        if (Level != '0) state_d = DRN_REQ;
        if (load_ok)     addr_d  = BaseAddr;
      end
      DRN_REQ: begin
        if (MemAck) begin
          pop    = 1'b1;
          addr_d = addr_q + A'(1);
          // Last entry leaves and nothing arrives on the same edge.
          if ((Level == LW'(1)) && !Capture) state_d = DRN_IDLE;
        end
      end
      default: state_d = DRN_IDLE;
    endcase

    if (load_ok)                     overflow_d = 1'b0;
    else if (Capture && Full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= DRN_IDLE;
      addr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      overflow_q <= overflow_d;
    end
  end

  assign Overflow = overflow_q;

endmodule

// File: tb/tb_acc_store_drain.sv
// Directed bench for acc_store_drain; expected stores are queued by the
// stimulus and compared by an independent monitor as the memory accepts them.
module tb_acc_store_drain;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Capture = 1'b0;
  logic [7:0] AccData = '0;
  logic       LoadBase = 1'b0;
  logic [7:0] BaseAddr = '0;
  logic       MemWrEn;
  logic [7:0] MemAddr;
  logic [7:0] MemData;
  logic       MemAck = 1'b0;
  logic       Full;
  logic       Empty;
  logic [2:0] Level;
  logic       Overflow;
  logic       Busy;

  acc_store_drain dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Capture  (Capture),
    .AccData  (AccData),
    .LoadBase (LoadBase),
    .BaseAddr (BaseAddr),
    .MemWrEn  (MemWrEn),
    .MemAddr  (MemAddr),
    .MemData  (MemData),
    .MemAck   (MemAck),
    .Full     (Full),
    .Empty    (Empty),
    .Level    (Level),
    .Overflow (Overflow),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } store_t;

  store_t exp_q[$];
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_store(input logic [7:0] addr, input logic [7:0] data);
    store_t s;
    s.addr = addr;
    s.data = data;
    exp_q.push_back(s);
  endtask

  // A store is committed at the posedge following a negedge that sees req and ack.
  always @(negedge Clk) begin
    store_t e;
    if (Reset_n && MemWrEn === 1'b1 && MemAck === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_store", {16'h0, MemAddr, MemData}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("store_addr", 32'(MemAddr), 32'(e.addr));
        check("store_data", 32'(MemData), 32'(e.data));
      end
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    check("rst_level",    32'(Level),    32'd0);
    check("rst_empty",    32'(Empty),    32'd1);
    check("rst_full",     32'(Full),     32'd0);
    check("rst_overflow", 32'(Overflow), 32'd0);
    check("rst_wren",     32'(MemWrEn),  32'd0);
    check("rst_busy",     32'(Busy),     32'd0);

    // 1: reset asserted mid-REQ clears immediately
    Capture = 1'b1; AccData = 8'h33;
    tick();
    Capture = 1'b0;
    tick();
    check("t1_in_req", 32'(MemWrEn), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("t1_wren",     32'(MemWrEn),  32'd0);
    check("t1_level",    32'(Level),    32'd0);
    check("t1_empty",    32'(Empty),    32'd1);
    check("t1_overflow", 32'(Overflow), 32'd0);
    check("t1_addr",     32'(MemAddr),  32'd0);
    check("t1_data",     32'(MemData),  32'd0);
    tick();
    Reset_n = 1'b1;
    tick();

    // 2: single store at base 10
    LoadBase = 1'b1; BaseAddr = 8'h10;
    tick();
    LoadBase = 1'b0;
    Capture = 1'b1; AccData = 8'hA5;
    expect_store(8'h10, 8'hA5);
    tick();
    Capture = 1'b0;
    check("t2_empty_after_cap", 32'(Empty),   32'd0);
    check("t2_wren_early",      32'(MemWrEn), 32'd0);
    tick();
    check("t2_wren",  32'(MemWrEn), 32'd1);
    check("t2_addr",  32'(MemAddr), 32'h10);
    check("t2_data",  32'(MemData), 32'hA5);
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    check("t2_empty_end", 32'(Empty),   32'd1);
    check("t2_wren_end",  32'(MemWrEn), 32'd0);

    // 3: stall keeps address/data stable
    Capture = 1'b1; AccData = 8'hB6;
    expect_store(8'h11, 8'hB6);
    tick();
    Capture = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_wren", 32'(MemWrEn), 32'd1);
      check("t3_addr", 32'(MemAddr), 32'h11);
      check("t3_data", 32'(MemData), 32'hB6);
      tick();
    end
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    check("t3_empty", 32'(Empty), 32'd1);

    // 4: overflow drops the fifth capture
    for (int i = 1; i <= 5; i++) begin
      Capture = 1'b1; AccData = 8'(i);
      if (i <= 4) expect_store(8'h11 + 8'(i), 8'(i));
      tick();
    end
    Capture = 1'b0;
    check("t4_full",     32'(Full),     32'd1);
    check("t4_level",    32'(Level),    32'd4);
    check("t4_overflow", 32'(Overflow), 32'd1);
    MemAck = 1'b1;
    repeat (4) tick();
    MemAck = 1'b0;
    check("t4_empty",       32'(Empty),    32'd1);
    check("t4_wren_end",    32'(MemWrEn),  32'd0);
    check("t4_ovf_sticky",  32'(Overflow), 32'd1);
    LoadBase = 1'b1; BaseAddr = 8'h40;
    tick();
    LoadBase = 1'b0;
    check("t4_ovf_cleared", 32'(Overflow), 32'd0);

    // 5: full FIFO accepts a push on the same edge as a pop
    for (int i = 0; i < 4; i++) begin
      Capture = 1'b1; AccData = 8'h61 + 8'(i);
      expect_store(8'h40 + 8'(i), 8'h61 + 8'(i));
      tick();
    end
    check("t5_full", 32'(Full), 32'd1);
    AccData = 8'h77; MemAck = 1'b1;
    expect_store(8'h44, 8'h77);
    tick();
    Capture = 1'b0;
    check("t5_level",    32'(Level),    32'd4);
    check("t5_overflow", 32'(Overflow), 32'd0);
    repeat (4) tick();
    MemAck = 1'b0;
    check("t5_empty", 32'(Empty), 32'd1);

    // 6: address wraps; LoadBase ignored while busy
    LoadBase = 1'b1; BaseAddr = 8'hFF;
    tick();
    LoadBase = 1'b0;
    Capture = 1'b1; AccData = 8'hC1;
    expect_store(8'hFF, 8'hC1);
    tick();
    AccData = 8'hC2;
    expect_store(8'h00, 8'hC2);
    tick();
    Capture = 1'b0;
    check("t6_busy", 32'(Busy), 32'd1);
    LoadBase = 1'b1; BaseAddr = 8'h80;
    tick();
    LoadBase = 1'b0;
    check("t6_addr_kept", 32'(MemAddr), 32'hFF);
    MemAck = 1'b1;
    repeat (2) tick();
    MemAck = 1'b0;
    Capture = 1'b1; AccData = 8'hD0;
    expect_store(8'h01, 8'hD0);
    tick();
    Capture = 1'b0;
    tick();
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    repeat (3) tick();
    check("pending_stores", 32'(exp_q.size()), 32'd0);
    check("final_empty",    32'(Empty),        32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
